transmitter: RTL and testbench

TRANSMITTER -- requirements
Module: transmitter

---
 rtl/spart_pkg.sv | 22 ++
 rtl/tx_bit_timer.sv | 23 ++
 rtl/transmitter.sv | 105 ++++++++++
 tb/tb_transmitter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared types and constants for the serial transmitter.
// Defining TX_PARITY_EN adds the even-parity state to the encoding.
package spart_pkg;
    localparam int TICKS_PER_BIT = 16;
    localparam int DATA_BITS     = 8;
    localparam int TICK_W        = $clog2(TICKS_PER_BIT);
    localparam int IDX_W         = $clog2(DATA_BITS);

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef TX_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } tx_state_t;
endpackage

// File: rtl/tx_bit_timer.sv
// Counts baud-enable ticks within one frame bit; bit_done pulses on the 15->0 wrap.
module tx_bit_timer
    import spart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic brg_en,
    input  logic clear,
    output logic bit_done
);
    logic [TICK_W-1:0] tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tick <= '0;
        else if (clear)
            tick <= '0;
        else if (brg_en)
            tick <= tick + 1'b1;
    end

    assign bit_done = brg_en && (tick == TICK_W'(TICKS_PER_BIT - 1));
endmodule

// File: rtl/transmitter.sv
// Double-buffered UART transmitter: 1 start, 8 data LSB first, 1 stop.
// Defining TX_PARITY_EN inserts an even-parity bit before the stop bit.
module transmitter
    import spart_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 brg_en,
    input  logic                 tx_load,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 TX,
    output logic                 TBR
);
    tx_state_t            state, state_nxt;
    logic [DATA_BITS-1:0] hold, shift;
    logic [IDX_W-1:0]     bit_idx;
    logic                 bit_done, timer_clear, transfer, tx_nxt;
`ifdef TX_PARITY_EN
    logic                 parity;
`endif

    // The tick counter is parked at 0 in IDLE, so START always begins from 0;
    // a STOP->START hand-off arrives on the natural 15->0 wrap.
    assign timer_clear = (state == S_IDLE);

    tx_bit_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .brg_en   (brg_en),
        .clear    (timer_clear),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!TBR) state_nxt = S_START;
            S_START: if (bit_done) state_nxt = S_DATA;
            S_DATA:  if (bit_done && bit_idx == IDX_W'(DATA_BITS - 1))
`ifdef TX_PARITY_EN
                         state_nxt = S_PARITY;
            S_PARITY: if (bit_done) state_nxt = S_STOP;
`else
                         state_nxt = S_STOP;
`endif
            S_STOP:  if (bit_done) state_nxt = TBR ? S_IDLE : S_START;
            default: state_nxt = S_IDLE;
        endcase
    end

    // TX is registered from the next state so the line changes on the same
    // edge as the state; in DATA the shift register moves on that edge too.
    always_comb begin
        tx_nxt = LINE_IDLE;
        case (state_nxt)
            S_START:  tx_nxt = LINE_START;
            S_DATA:   tx_nxt = (state == S_DATA && bit_done) ? shift[1] : shift[0];
`ifdef TX_PARITY_EN
            S_PARITY: tx_nxt = parity;
`endif
            S_STOP:   tx_nxt = LINE_STOP;
            default:  tx_nxt = LINE_IDLE;
        endcase
    end

    assign transfer = (state_nxt == S_START) && (state != S_START);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            TX      <= LINE_IDLE;
            TBR     <= 1'b1;
            hold    <= '0;
            shift   <= '0;
            bit_idx <= '0;
`ifdef TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            TX <= tx_nxt;
            // transfer requires TBR=0, so it never collides with an accepted load
            if (tx_load && TBR) begin
                hold <= tx_data;
                TBR  <= 1'b0;
            end
            if (transfer) begin
                shift   <= hold;
                TBR     <= 1'b1;
                bit_idx <= '0;
`ifdef TX_PARITY_EN
                parity  <= ^hold;
`endif
            end else if (state == S_DATA && bit_done) begin
                shift   <= shift >> 1;
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_transmitter.sv
// Scoreboard bench for transmitter: a line monitor decodes frames and pops expectations.
// Frame length follows TX_PARITY_EN.
module tb_transmitter;
`ifdef TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int BIT_CLK = 64;

    logic       clk = 1'b0, rst = 1'b0, brg_en = 1'b0, tx_load = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       TX, TBR;

    transmitter dut (
        .clk     (clk),
        .rst     (rst),
        .brg_en  (brg_en),
        .tx_load (tx_load),
        .tx_data (tx_data),
        .TX      (TX),
        .TBR     (TBR)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // baud enable every 4 clocks, gateable
    logic       brg_on = 1'b1;
    logic [1:0] div = 2'd0;
    always @(posedge clk) begin
        div    <= div + 2'd1;
        brg_en <= brg_on && (div == 2'd3);
    end

    int checks = 0, errors = 0;
    logic [10:0] exp_q[$];
    int frame_starts[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d);
`ifdef TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    // line monitor: sample each bit mid-way after the start edge
    logic        mon_busy = 1'b0;
    int          mon_cnt = 0, mon_nbit = 0;
    logic [10:0] mon_bits = '0;
    always @(negedge clk) begin
        if (!rst) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (TX == 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
                mon_nbit = 0;
                mon_bits = '0;
                frame_starts.push_back(cyc);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == BIT_CLK / 2 + BIT_CLK * mon_nbit) begin
                mon_bits[mon_nbit] = TX;
                mon_nbit++;
                if (mon_nbit == FRAME_BITS) begin
                    mon_busy = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %0h expected none", mon_bits);
                    end else begin
                        check("frame", 32'(mon_bits), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic load(input logic [7:0] d);
        @(posedge clk); #1;
        tx_load = 1'b1;
        tx_data = d;
        @(posedge clk); #1;
        tx_load = 1'b0;
    endtask

    task automatic wait_tx(input logic v, input int bound, input string name);
        int n = 0;
        while (TX !== v && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        if (TX !== v) check(name, 32'(TX), 32'(v));
    endtask

    task automatic wait_empty(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        check("frames_drained", exp_q.size(), 0);
    endtask

    initial begin
        int t0, diff, odd;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_TX", 32'(TX), 1);
        check("reset_TBR", 32'(TBR), 1);
        rst = 1'b1;
        repeat (5) @(posedge clk);

        // single byte A5: TBR low one cycle, start bit one cycle later
        exp_q.push_back(11'b0_1_10100101_0);
        load(8'hA5);
        check("a5_tbr_n1", 32'(TBR), 0);
        check("a5_tx_n1", 32'(TX), 1);
        @(posedge clk); #1;
        check("a5_tbr_n2", 32'(TBR), 1);
        check("a5_tx_n2", 32'(TX), 0);
        wait_tx(1'b1, 100, "a5_d0_timeout");
        t0 = cyc;
        wait_tx(1'b0, 100, "a5_d1_timeout");
        check("a5_bit_width", cyc - t0, BIT_CLK);
        wait_empty(1000);
        repeat (40) @(posedge clk); #1;
        check("a5_idle_TX", 32'(TX), 1);

        // back-to-back 3C/C3, third load ignored while holding full
        frame_starts.delete();
        exp_q.push_back(mk(8'h3C));
        load(8'h3C);
        wait_tx(1'b0, 10, "3c_start_timeout");
        repeat (100) @(posedge clk); #1;
        check("3c_tbr_before", 32'(TBR), 1);
        exp_q.push_back(mk(8'hC3));
        load(8'hC3);
        check("c3_accepted_tbr", 32'(TBR), 0);
        load(8'hAA);
        check("aa_ignored_tbr", 32'(TBR), 0);
        t0 = 0;
        while (TBR !== 1'b1 && t0 < 1000) begin
            @(posedge clk); #1;
            t0++;
        end
        check("c3_start_tbr", 32'(TBR), 1);
        check("c3_start_tx", 32'(TX), 0);
        wait_empty(1000);
        repeat (1500) @(posedge clk);
        check("two_frames", frame_starts.size(), 2);
        if (frame_starts.size() >= 2) begin
            diff = frame_starts[1] - frame_starts[0];
            check("contiguous", 32'(diff >= (FRAME_BITS - 1) * BIT_CLK + 61 &&
                                  diff <= (FRAME_BITS - 1) * BIT_CLK + 64), 1);
        end

        // parity cases (plain frames when parity is disabled)
`ifdef TX_PARITY_EN
        exp_q.push_back(11'b1_1_00000111_0);
`else
        exp_q.push_back(11'b0_1_00000111_0);
`endif
        load(8'h07);
        wait_empty(1000);
`ifdef TX_PARITY_EN
        exp_q.push_back(11'b1_0_00000011_0);
`else
        exp_q.push_back(11'b0_1_00000011_0);
`endif
        load(8'h03);
        wait_empty(1000);
        repeat (40) @(posedge clk);

        // reset in the middle of data bit 4 of FF with a second byte queued
        load(8'hFF);
        wait_tx(1'b0, 10, "ff_start_timeout");
        load(8'h00);
        check("ff_queued_tbr", 32'(TBR), 0);
        repeat (330) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midframe_rst_TX", 32'(TX), 1);
        check("midframe_rst_TBR", 32'(TBR), 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        odd = 0;
        repeat (1500) begin
            @(posedge clk); #1;
            if (TX !== 1'b1) odd++;
        end
        check("quiet_after_rst", odd, 0);
        check("quiet_tbr", 32'(TBR), 1);

        // baud enable stopped: line held in START
        brg_on = 1'b0;
        repeat (4) @(posedge clk);
        load(8'h55);
        @(posedge clk); #1;
        check("stall_start_TX", 32'(TX), 0);
        odd = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (TX !== 1'b0) odd++;
        end
        check("stall_held", odd, 0);
        rst = 1'b0;
        #1;
        check("stall_rst_TX", 32'(TX), 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        brg_on = 1'b1;
        repeat (800) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
